sound_pwm_out: RTL and testbench
================================

# sound_pwm_out

Output-side consumer of the sound channel stream. Accepts 16-bit signed samples, each qualified by a one-cycle start strobe as produced by the channel volume stage, and buffers them in a small FIFO. Each buffered sample drives one period of a pulse-width-modulated buzzer pin. The block sits between the per-channel sound generator output and the physical buzzer pin.

## Interface
Parameters:
- PWM_BITS, 8: duty resolution. PWM period = 2^PWM_BITS clocks. Legal range 4..12.
- DEPTH, 4: FIFO depth in samples. Power of two, 2..16.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-high reset.
- soundIn  in  16  signed two's-complement sample.
- startI  in  1  one-cycle strobe; soundIn is valid in the same cycle.
- clrFlags  in  1  synchronous clear of the sticky overflow/underrun flags.
- pwmOut  out  1  registered PWM output to the buzzer.
- level  out  log2(DEPTH)+1  FIFO occupancy.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: a sample was dropped.
- underrun  out  1  sticky: a period boundary found the FIFO empty.

## Operation
- **Conversion on write:** the stored value is soundIn with bit 15 inverted, giving offset binary. Only bits [15:16-PWM_BITS] are stored.
  - 16'h8000 maps to duty 0.
  - 16'h0000 maps to midscale 2^(PWM_BITS-1).
  - 16'h7FFF maps to duty 2^PWM_BITS-1.
- **Push:** startI=1 is accepted when !full, or when a pop occurs in the same cycle.
  - Otherwise the sample is dropped and overflow is set.
  - startI with no pop while full is always a drop.
- **Period counter:** cnt is PWM_BITS wide, free-running, increments every clock and wraps from 2^PWM_BITS-1 to 0.
- **Pop:** occurs only in the cycle where cnt == 2^PWM_BITS-1 (the boundary cycle).
  - If level>0, the head entry is loaded into duty and removed.
  - If level==0, duty holds its previous value and underrun is set.
  - There is no bypass: a push in the same cycle as a pop on an empty FIFO does not feed the pop. It is stored, and level becomes 1.
- **Simultaneous push and pop** with a non-empty FIFO: level is unchanged and the order is preserved. When full, the push is accepted.
- **Output:** pwmOut <= (cnt < duty). Duty 0 gives a constantly low output. Duty max gives high for 2^PWM_BITS-1 of 2^PWM_BITS clocks.
- **Flags:** overflow and underrun are sticky until clrFlags=1. If a set event coincides with clrFlags, the set wins.
- **FIFO storage:** circular buffer with read/write pointers that wrap modulo DEPTH.

## Timing
- **Reset values (applied asynchronously):**
  - pwmOut=0, cnt=0, duty=2^(PWM_BITS-1) (midscale, silent).
  - level=0, full=0, overflow=0, underrun=0.
  - FIFO pointers at 0.
- **Reset mid-operation:** all of the above apply immediately. FIFO contents are discarded.
- **Push latency:** startI at edge t; level and full update at t+1.
- **Pop to output:** a pop at the boundary cycle loads duty at the same edge that cnt wraps to 0. The new duty appears on pwmOut one clock later because pwmOut is registered. The PWM waveform is therefore delayed by 1 clock relative to cnt.
- **First period after reset:** pwmOut is high for 2^(PWM_BITS-1) consecutive clocks, starting 1 clock after reset release.
- **Flags:** become visible the edge after the causing event.
- **Sample-rate matching:** the upstream stage must deliver on average at most one sample per PWM period. Any excess is reported through overflow.

## Test plan
All scenarios use PWM_BITS=8, DEPTH=4.
- **Reset:** assert rst asynchronously between edges → outputs immediately show pwmOut=0, level=0, full=0, flags=0. After release, pwmOut is high 128 clocks, low 128 clocks, repeating.
- **Full scale:** push 16'h7FFF once → level=1, then 0 after the next boundary. The following period has pwmOut high 255 clocks and low 1 clock.
- **Zero duty:** push 16'h8000 → in the period after the pop, pwmOut is low for all 256 clocks. A subsequent empty boundary holds duty 0 and sets underrun=1.
- **Overflow:** push 5 samples on consecutive clocks, away from any boundary → level=4, full=1, 5th sample dropped, overflow=1. Pulse clrFlags → overflow=0. FIFO drains in order, one sample per 256 clocks.
- **Push on full at boundary:** fill the FIFO to 4, then strobe startI in the boundary cycle → sample accepted, level stays 4, overflow stays 0.
- **Reset mid-operation:** with level=3 and duty=200, assert rst mid-period → level=0, duty=128, pwmOut=0 at once. No stale samples appear after release.

Source files
------------

// File: rtl/sound_pwm_out.sv
// Sample FIFO feeding a registered PWM buzzer output; one buffered sample drives one
// full PWM period, with sticky overflow/underrun reporting toward the upstream stage.
module sound_pwm_out #(
  parameter int PWM_BITS = 8,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [15:0]        soundIn,
  input  logic                      startI,
  input  logic                      clrFlags,
  output logic                      pwmOut,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      overflow,
  output logic                      underrun
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  // Offset-binary conversion: flip the sign bit, keep the top PWM_BITS bits.
  function automatic logic [PWM_BITS-1:0] to_duty(input logic signed [15:0] s);
    logic [15:0] u;
    u = {~s[15], s[14:0]};
    return PWM_BITS'(u >> (16 - PWM_BITS));
  endfunction

  logic [PWM_BITS-1:0] mem [DEPTH];
  logic [PWM_BITS-1:0] sample_p0;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] duty;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                boundary;
  logic                pop;
  logic                push;
  logic                drop;
  logic                starve;

  assign sample_p0 = to_duty(soundIn);
  assign full      = (level == LW'(DEPTH));
  assign boundary  = (cnt == '1);
  assign pop       = boundary && (level != '0);
  assign starve    = boundary && (level == '0);
  assign push      = startI && (!full || pop);
  assign drop      = startI && !push;

  // Sample storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      duty     <= PWM_BITS'(1) << (PWM_BITS - 1);
      pwmOut   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt    <= cnt + PWM_BITS'(1);
      pwmOut <= (cnt < duty);
      if (pop) begin
        duty   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      // A set event in the same cycle as a clear keeps the flag set.
      if (drop)          overflow <= 1'b1;
      else if (clrFlags) overflow <= 1'b0;
      if (starve)        underrun <= 1'b1;
      else if (clrFlags) underrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sound_pwm_out.sv
// Randomized and directed bench for sound_pwm_out against a queue-based period model.
module tb_sound_pwm_out;

  localparam int P      = 8;
  localparam int D      = 4;
  localparam int PERIOD = 2 ** P;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] soundIn = '0;
  logic               startI = 1'b0;
  logic               clrFlags = 1'b0;
  logic               pwmOut;
  logic [2:0]         level;
  logic               full;
  logic               overflow;
  logic               underrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int ph_m;
  int duty_m;
  int pwm_m;
  int ovf_m;
  int und_m;
  int q_m[$];

  sound_pwm_out #(.PWM_BITS(P), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .soundIn(soundIn), .startI(startI), .clrFlags(clrFlags),
    .pwmOut(pwmOut), .level(level), .full(full), .overflow(overflow), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int conv(input logic signed [15:0] s);
    int v;
    v = int'(s) + 32768;
    return v / (2 ** (16 - P));
  endfunction

  task automatic model_reset();
    ph_m = 0; duty_m = PERIOD / 2; pwm_m = 0; ovf_m = 0; und_m = 0;
    q_m.delete();
  endtask

  task automatic model_clock();
    bit pop_now, accept;
    pwm_m   = (ph_m < duty_m) ? 1 : 0;
    pop_now = (ph_m == PERIOD - 1) && (q_m.size() > 0);
    accept  = startI && ((q_m.size() < D) || pop_now);
    if (ph_m == PERIOD - 1) begin
      if (q_m.size() > 0) duty_m = q_m.pop_front();
      else                und_m  = 1;
    end else if (clrFlags) und_m = 0;
    if (ph_m == PERIOD - 1 && pop_now && clrFlags) und_m = 0;
    if (accept) q_m.push_back(conv(soundIn));
    if (startI && !accept) ovf_m = 1;
    else if (clrFlags)     ovf_m = 0;
    ph_m = (ph_m + 1) % PERIOD;
  endtask

  task automatic compare_all();
    check("pwmOut", pwmOut, pwm_m);
    check("level", level, q_m.size());
    check("full", full, (q_m.size() == D) ? 1 : 0);
    check("overflow", overflow, ovf_m);
    check("underrun", underrun, und_m);
  endtask

  task automatic cyc(input bit s, input logic signed [15:0] d, input bit c);
    startI = s; soundIn = d; clrFlags = c;
    @(posedge clk);
    model_clock();
    @(negedge clk);
    compare_all();
    startI = 1'b0; clrFlags = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic run_until_ph(input int target);
    while (ph_m != target) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    idle((D + 1) * PERIOD);
    cyc(1'b0, '0, 1'b1);
  endtask

  int hi_cnt;

  initial begin
    model_reset();
    // Power-on reset
    repeat (2) @(negedge clk);
    check("rst_pwm", pwmOut, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_und", underrun, 0);
    rst = 1'b0;

    // Idle periods: 128 high / 128 low, first high sample one clock after release
    hi_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cyc(1'b0, '0, 1'b0);
      hi_cnt += pwmOut;
    end
    check("idle_high_count", hi_cnt, PERIOD / 2);
    idle(PERIOD);
    cyc(1'b0, '0, 1'b1);

    // Full scale
    run_until_ph(30);
    cyc(1'b1, 16'sh7FFF, 1'b0);
    check("fs_level", level, 1);
    run_until_ph(0);
    check("fs_popped", level, 0);
    hi_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cyc(1'b0, '0, 1'b0);
      hi_cnt += pwmOut;
    end
    check("fs_high_count", hi_cnt, PERIOD - 1);

    // Zero duty, followed by an empty boundary
    cyc(1'b0, '0, 1'b1);
    run_until_ph(40);
    cyc(1'b1, -16'sh8000, 1'b0);
    run_until_ph(0);
    hi_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cyc(1'b0, '0, 1'b0);
      hi_cnt += pwmOut;
    end
    check("zero_high_count", hi_cnt, 0);
    check("zero_underrun", underrun, 1);

    // Overflow burst of 5 away from the boundary, then clear and drain in order
    drain();
    run_until_ph(10);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(i * 16'sh1800), 1'b0);
    check("ovf_level", level, 4);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    cyc(1'b0, '0, 1'b1);
    check("ovf_cleared", overflow, 0);
    drain();

    // Push on full in the boundary cycle
    run_until_ph(20);
    for (int i = 0; i < 4; i++) cyc(1'b1, 16'($urandom), 1'b0);
    run_until_ph(PERIOD - 1);
    cyc(1'b1, 16'sh1234, 1'b0);
    check("bnd_level", level, 4);
    check("bnd_ovf", overflow, 0);
    drain();

    // Randomized traffic with occasional bursts and clears
    for (int i = 0; i < 6000; i++) begin
      cyc(($urandom_range(0, 149) == 0) || ($urandom_range(0, 999) < 3),
          16'($urandom), $urandom_range(0, 299) == 0);
    end
    drain();

    // Reset mid-operation with duty 200 and three queued samples
    run_until_ph(100);
    cyc(1'b1, 16'sh4800, 1'b0);
    run_until_ph(0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'($urandom), 1'b0);
    check("mid_level", level, 3);
    run_until_ph(60);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("mid_rst_pwm", pwmOut, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_full", full, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_und", underrun, 0);
    @(negedge clk);
    rst = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cyc(1'b0, '0, 1'b0);
      hi_cnt += pwmOut;
    end
    check("post_rst_high_count", hi_cnt, PERIOD / 2);
    idle(2 * PERIOD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
